// File: rtl/soc_network_adapter_wb_front.sv
// Wishbone slave front end that turns single and incrementing-burst cycles
// into 16-bit byte-addressed target accesses with retry and timeout handling.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wb_adr_i .. wb_bte_i      Wishbone slave request inputs
//   wb_dat_o, wb_ack_o,
//   wb_err_o, wb_rty_o        registered Wishbone responses (rty never set)
//   tgt_adr, tgt_we,
//   tgt_data_o                registered target request
//   tgt_data_i, tgt_ack,
//   tgt_rty, tgt_err          target response, sampled only in ACCESS
module soc_network_adapter_wb_front #(
   parameter int DW        = 32,
   parameter int AW        = 32,
   parameter int RETRY_MAX = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic [DW/8-1:0] wb_sel_i,
   input  logic            wb_we_i,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic [2:0]      wb_cti_i,
   input  logic [1:0]      wb_bte_i,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic            wb_rty_o,
   output logic [15:0]     tgt_adr,
   output logic            tgt_we,
   output logic [DW-1:0]   tgt_data_o,
   input  logic [DW-1:0]   tgt_data_i,
   input  logic            tgt_ack,
   input  logic            tgt_rty,
   input  logic            tgt_err
);

   localparam int RW = $clog2(RETRY_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t          state, state_n;
   logic            we_q, we_n;
   logic [2:0]      cti_q, cti_n;
   logic [RW-1:0]   rcnt, rcnt_n;
   logic [TW-1:0]   tcnt, tcnt_n;
   logic [15:0]     adr_n;
   logic [DW-1:0]   wdat_n, dat_n;
   logic            ack_n, err_n, tgt_we_n;

   logic            req, sel_full, bte_bad;
   logic            bad_idle, bad_adv;
   logic [RW-1:0]   rcnt_inc;
   logic            unused_ok;

   assign req       = wb_cyc_i & wb_stb_i;
   assign sel_full  = &wb_sel_i;
   // Wrapping bursts are not supported; only linear incrementing ones.
   assign bte_bad   = (wb_cti_i == 3'b010) & (wb_bte_i != 2'b00);
   // Byte-lane writes cannot be expressed on the target port.
   assign bad_idle  = (wb_we_i & ~sel_full) | bte_bad;
   assign bad_adv   = (we_q & ~sel_full) | bte_bad;
   assign rcnt_inc  = rcnt + RW'(1);
   assign unused_ok = ^wb_adr_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         cti_q      <= 3'b000;
         rcnt       <= '0;
         tcnt       <= '0;
         tgt_adr    <= 16'h0000;
         tgt_data_o <= '0;
         tgt_we     <= 1'b0;
         wb_dat_o   <= '0;
         wb_ack_o   <= 1'b0;
         wb_err_o   <= 1'b0;
         wb_rty_o   <= 1'b0;
      end else begin
         state      <= state_n;
         we_q       <= we_n;
         cti_q      <= cti_n;
         rcnt       <= rcnt_n;
         tcnt       <= tcnt_n;
         tgt_adr    <= adr_n;
         tgt_data_o <= wdat_n;
         tgt_we     <= tgt_we_n;
         wb_dat_o   <= dat_n;
         wb_ack_o   <= ack_n;
         wb_err_o   <= err_n;
         wb_rty_o   <= 1'b0;
      end
   end

   always_comb begin
      state_n  = state;
      we_n     = we_q;
      cti_n    = cti_q;
      rcnt_n   = rcnt;
      tcnt_n   = tcnt;
      adr_n    = tgt_adr;
      wdat_n   = tgt_data_o;
      dat_n    = wb_dat_o;
      ack_n    = 1'b0;
      err_n    = 1'b0;
      tgt_we_n = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               adr_n  = wb_adr_i[15:0];
               wdat_n = wb_dat_i;
               we_n   = wb_we_i;
               cti_n  = wb_cti_i;
               rcnt_n = '0;
               tcnt_n = '0;
               // Illegal requests answer err straight away and
               // never reach the target.
               if (bad_idle) begin
                  err_n   = 1'b1;
                  state_n = RESP;
               end else begin
                  tgt_we_n = wb_we_i & sel_full;
                  state_n  = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!wb_cyc_i) begin
               state_n = IDLE;
            end else if (tgt_ack) begin
               dat_n   = tgt_data_i;
               ack_n   = 1'b1;
               state_n = RESP;
            end else if (tgt_err) begin
               err_n   = 1'b1;
               state_n = RESP;
            end else if (tgt_rty) begin
               rcnt_n = rcnt_inc;
               if (rcnt_inc == RW'(RETRY_MAX)) begin
                  err_n   = 1'b1;
                  state_n = RESP;
               end else begin
                  // Re-issue: one write strobe per attempt.
                  tgt_we_n = we_q & sel_full;
               end
            end else begin
               tcnt_n = tcnt + TW'(1);
               if (tcnt == TW'(TIMEOUT - 1)) begin
                  err_n   = 1'b1;
                  state_n = RESP;
               end
            end
         end
         RESP: begin
            state_n = IDLE;
            // Burst advance only after a good beat of an
            // incrementing burst that the master keeps open.
            if (cti_q == 3'b010 && wb_ack_o && req) begin
               adr_n  = tgt_adr + 16'd4;
               wdat_n = wb_dat_i;
               cti_n  = wb_cti_i;
               rcnt_n = '0;
               tcnt_n = '0;
               if (bad_adv) begin
                  err_n   = 1'b1;
                  state_n = RESP;
               end else begin
                  tgt_we_n = we_q & sel_full;
                  state_n  = ACCESS;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_soc_network_adapter_wb_front.sv
// Scoreboard bench for soc_network_adapter_wb_front: directed Wishbone
// requests against a small target model, responses checked by a monitor.
module tb_soc_network_adapter_wb_front;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_adr_i, wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o, wb_rty_o;
   logic [15:0] tgt_adr;
   logic        tgt_we;
   logic [31:0] tgt_data_o, tgt_data_i;
   logic        tgt_ack, tgt_rty, tgt_err;

   // 0: zero-wait ack (err in 0xF0xx), 1: silent, 2: retry forever
   logic [1:0]  tmode;

   typedef struct {
      logic        err;
      logic        chk;
      logic [31:0] dat;
   } exp_t;

   typedef struct {
      logic [15:0] adr;
      logic [31:0] dat;
   } wr_t;

   exp_t exp_q[$];
   wr_t  wr_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   soc_network_adapter_wb_front dut (
      .clk        (clk),
      .rst        (rst),
      .wb_adr_i   (wb_adr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_sel_i   (wb_sel_i),
      .wb_we_i    (wb_we_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_cti_i   (wb_cti_i),
      .wb_bte_i   (wb_bte_i),
      .wb_dat_o   (wb_dat_o),
      .wb_ack_o   (wb_ack_o),
      .wb_err_o   (wb_err_o),
      .wb_rty_o   (wb_rty_o),
      .tgt_adr    (tgt_adr),
      .tgt_we     (tgt_we),
      .tgt_data_o (tgt_data_o),
      .tgt_data_i (tgt_data_i),
      .tgt_ack    (tgt_ack),
      .tgt_rty    (tgt_rty),
      .tgt_err    (tgt_err)
   );

   always #5 clk = ~clk;

   // Target model: read data is the byte address shifted left by 2.
   always_comb begin
      tgt_ack    = 1'b0;
      tgt_err    = 1'b0;
      tgt_rty    = 1'b0;
      tgt_data_i = {14'h0, tgt_adr, 2'b00};
      case (tmode)
         2'd0: begin
            if (tgt_adr[15:8] == 8'hF0) tgt_err = 1'b1;
            else tgt_ack = 1'b1;
         end
         2'd2: tgt_rty = 1'b1;
         default: ;
      endcase
   end

   // Monitor: pops expectations whenever the DUT presents a response
   // or a target write strobe.
   exp_t me;
   wr_t  mw;
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (wb_ack_o || wb_err_o) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_resp got ack=%b err=%b want none",
                        wb_ack_o, wb_err_o);
            end else begin
               me = exp_q.pop_front();
               if (wb_ack_o !== !me.err || wb_err_o !== me.err ||
                   (me.chk && wb_dat_o !== me.dat)) begin
                  n_fail++;
                  $display("FAIL resp got ack=%b err=%b dat=%h want err=%b dat=%h",
                           wb_ack_o, wb_err_o, wb_dat_o, me.err, me.dat);
               end
            end
         end
         if (tgt_we) begin
            n_tests++;
            if (wr_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_we got adr=%h dat=%h want no write",
                        tgt_adr, tgt_data_o);
            end else begin
               mw = wr_q.pop_front();
               if (tgt_adr !== mw.adr || tgt_data_o !== mw.dat) begin
                  n_fail++;
                  $display("FAIL tgt_write got adr=%h dat=%h want adr=%h dat=%h",
                           tgt_adr, tgt_data_o, mw.adr, mw.dat);
               end
            end
         end
         if (wb_rty_o !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wb_rty_o got %b want 0", wb_rty_o);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic push_resp(input logic err, input logic chk,
                            input logic [31:0] dat);
      exp_t e;
      e.err = err;
      e.chk = chk;
      e.dat = dat;
      exp_q.push_back(e);
   endtask

   task automatic push_wr(input logic [15:0] adr, input logic [31:0] dat);
      wr_t w;
      w.adr = adr;
      w.dat = dat;
      wr_q.push_back(w);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ack"}, 32'(wb_ack_o), 32'h0);
      check({tag, "_err"}, 32'(wb_err_o), 32'h0);
      check({tag, "_rty"}, 32'(wb_rty_o), 32'h0);
      check({tag, "_we"}, 32'(tgt_we), 32'h0);
      check({tag, "_dat_o"}, wb_dat_o, 32'h0);
      check({tag, "_adr"}, 32'(tgt_adr), 32'h0);
      check({tag, "_tdat"}, tgt_data_o, 32'h0);
   endtask

   // Wait for ack/err, bounded; returns negedges elapsed (0 on timeout).
   task automatic wait_resp(input string name, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(wb_ack_o || wb_err_o) && lat < 100);
      if (!(wb_ack_o || wb_err_o)) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout got no response want ack/err", name);
         lat = 0;
      end
   endtask

   task automatic do_req(input string name, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input logic [2:0] cti,
                         input logic [1:0] bte, input int exp_lat);
      int lat;
      @(negedge clk);
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      wb_we_i  = we;
      wb_cti_i = cti;
      wb_bte_i = bte;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wait_resp(name, lat);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
   endtask

   task automatic do_burst(input string name, input logic [15:0] base,
                           input int beats);
      int lat;
      logic [15:0] a;
      a = base;
      for (int i = 0; i < beats; i++) begin
         push_resp(1'b0, 1'b1, {14'h0, a, 2'b00});
         a = a + 16'd4;
      end
      @(negedge clk);
      wb_adr_i = {16'h0, base};
      wb_dat_i = 32'h0;
      wb_sel_i = 4'hF;
      wb_we_i  = 1'b0;
      wb_bte_i = 2'b00;
      wb_cti_i = (beats > 1) ? 3'b010 : 3'b111;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      a = base;
      for (int b = 0; b < beats; b++) begin
         wait_resp(name, lat);
         check({name, "_lat"}, 32'(lat), 32'd2);
         check({name, "_adr"}, 32'(tgt_adr), 32'(a));
         a = a + 16'd4;
         wb_cti_i = (b + 1 == beats - 1) ? 3'b111 : 3'b010;
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
   endtask

   initial begin
      int lat;
      rst      = 1'b1;
      tmode    = 2'd0;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_sel_i = '0;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_cti_i = 3'b000;
      wb_bte_i = 2'b00;
      repeat (3) @(negedge clk);
      check_reset_vals("rst0");
      rst = 1'b0;
      @(negedge clk);

      // single read, zero-wait target
      push_resp(1'b0, 1'b1, 32'h0000_0010);
      do_req("rd4", 32'h4, 32'h0, 4'hF, 1'b0, 3'b000, 2'b00, 2);
      repeat (3) @(negedge clk);
      check("dat_hold", wb_dat_o, 32'h0000_0010);

      // full and partial writes
      push_wr(16'h0108, 32'h5);
      push_resp(1'b0, 1'b0, 32'h0);
      do_req("wr_full", 32'h108, 32'h5, 4'hF, 1'b1, 3'b000, 2'b00, 2);
      push_resp(1'b1, 1'b0, 32'h0);
      do_req("wr_part", 32'h108, 32'h5, 4'h3, 1'b1, 3'b000, 2'b00, 1);

      // unsupported burst type
      push_resp(1'b1, 1'b0, 32'h0);
      do_req("bte", 32'h20, 32'h0, 4'hF, 1'b0, 3'b010, 2'b01, 1);

      // target error, retry exhaustion, silent target
      push_resp(1'b1, 1'b0, 32'h0);
      do_req("tgt_err", 32'hF000, 32'h0, 4'hF, 1'b0, 3'b000, 2'b00, 2);
      tmode = 2'd2;
      push_resp(1'b1, 1'b0, 32'h0);
      do_req("retry", 32'h30, 32'h0, 4'hF, 1'b0, 3'b000, 2'b00, 5);
      tmode = 2'd1;
      push_resp(1'b1, 1'b0, 32'h0);
      do_req("tmo", 32'h34, 32'h0, 4'hF, 1'b0, 3'b000, 2'b00, 17);
      check("dat_after_err", wb_dat_o, 32'h0000_0420);
      tmode = 2'd0;

      // bursts, including 16-bit address wrap
      do_burst("burst", 16'h0200, 4);
      do_burst("wrap", 16'hFFFC, 2);

      // cyc dropped while a write is in ACCESS
      tmode = 2'd1;
      push_wr(16'h0040, 32'hAB);
      @(negedge clk);
      wb_adr_i = 32'h40;
      wb_dat_i = 32'hAB;
      wb_sel_i = 4'hF;
      wb_we_i  = 1'b1;
      wb_cti_i = 3'b000;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      @(negedge clk);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      @(negedge clk);
      check("abort_we", 32'(tgt_we), 32'h0);
      tmode = 2'd0;
      push_resp(1'b0, 1'b1, 32'h0000_0100);
      do_req("after_abort", 32'h40, 32'h0, 4'hF, 1'b0, 3'b000, 2'b00, 2);

      // reset while in ACCESS
      tmode = 2'd1;
      @(negedge clk);
      wb_adr_i = 32'h50;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_acc");
      rst      = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      tmode    = 2'd0;

      // reset while in RESP of a burst beat
      push_resp(1'b0, 1'b1, 32'h0000_0C00);
      @(negedge clk);
      wb_adr_i = 32'h300;
      wb_cti_i = 3'b010;
      wb_bte_i = 2'b00;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wait_resp("rst_resp", lat);
      #1 rst = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_resp");
      rst      = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_cti_i = 3'b000;
      repeat (4) @(negedge clk);

      check("resp_q_empty", 32'(exp_q.size()), 32'h0);
      check("wr_q_empty", 32'(wr_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/soc_network_adapter_wb_front.md
SOC_NETWORK_ADAPTER_WB_FRONT -- requirements
Module: soc_network_adapter_wb_front

Interface
REQ-001 SHALL have parameter DW, default 32, data width of the bus and target ports.
REQ-002 SHALL have parameter AW, default 32, Wishbone address width.
REQ-003 SHALL have parameter RETRY_MAX, default 4, number of target rty responses tolerated before err.
REQ-004 SHALL have parameter TIMEOUT, default 16, number of ACCESS cycles without a target response before err.
REQ-005 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-007 SHALL have Wishbone slave inputs wb_adr_i AW, wb_dat_i DW, wb_sel_i DW/8, wb_we_i 1, wb_cyc_i 1, wb_stb_i 1, wb_cti_i 3, wb_bte_i 2.
REQ-008 SHALL have Wishbone slave outputs wb_dat_o DW, wb_ack_o 1, wb_err_o 1, wb_rty_o 1, all registered.
REQ-009 SHALL have target outputs tgt_adr 16 (byte address), tgt_we 1 (write strobe) and tgt_data_o DW (write data), all registered.
REQ-010 SHALL have target inputs tgt_data_i DW (read data), tgt_ack 1, tgt_rty 1 and tgt_err 1, all sampled in ACCESS.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-012 IDLE: on wb_cyc_i&wb_stb_i, SHALL latch tgt_adr=wb_adr_i[15:0], tgt_data_o=wb_dat_i, we and cti, then go to ACCESS.
REQ-013 SHALL assert tgt_we only in ACCESS, only if the latched we=1 and wb_sel_i is all ones.
REQ-014 Write with partial wb_sel_i: SHALL issue no target write and SHALL respond err in RESP.
REQ-015 wb_bte_i!=00 with wb_cti_i=010: SHALL respond err without target access.
REQ-016 ACCESS with tgt_ack=1 (priority over err/rty): SHALL capture tgt_data_i into wb_dat_o and go to RESP with ack.
REQ-017 ACCESS with tgt_err=1 and tgt_ack=0: SHALL go to RESP with err.
REQ-018 ACCESS with tgt_rty=1 only: SHALL increment retry counter and stay in ACCESS, re-issuing the request the next cycle.
REQ-019 When the retry counter reaches RETRY_MAX, SHALL go to RESP with err; wb_rty_o SHALL never be asserted.
REQ-020 ACCESS with no response: SHALL increment timeout counter; at TIMEOUT cycles SHALL go to RESP with err.
REQ-021 Retry and timeout counters SHALL clear on each entry to ACCESS from IDLE or from burst advance.
REQ-022 RESP: SHALL assert exactly one of wb_ack_o/wb_err_o for exactly one cycle.
REQ-023 Single-access latency: request sampled in IDLE at cycle N, ACCESS at N+1, ack/err visible at N+2 with zero-wait target.
REQ-024 RESP, latched cti=010, ack response, cyc&stb still high: SHALL add 4 to tgt_adr (mod 2^16), latch new wb_dat_i/cti, return to ACCESS.
REQ-025 Otherwise, including cti=111 or 000, or err response, RESP SHALL return to IDLE.
REQ-026 Address wrap: tgt_adr 16'hFFFC plus 4 SHALL give 16'h0000.
REQ-027 wb_cyc_i deasserted in ACCESS: SHALL abort to IDLE next cycle with no ack/err and tgt_we low.
REQ-028 wb_dat_o SHALL hold its last captured value outside RESP.
REQ-029 tgt_we SHALL never be high for more than one cycle per retry attempt.

Reset
REQ-030 On rst: SHALL enter IDLE and clear wb_ack_o, wb_err_o, wb_rty_o, tgt_we, both counters, wb_dat_o, tgt_adr and tgt_data_o to 0.
REQ-031 rst during ACCESS or RESP: SHALL discard the transaction with no response issued.

Verification
REQ-032 Single read, adr=0x0000_0004, target acks at once with 0x0000_0010: ack at cycle N+2 with wb_dat_o=0x10; tgt_we never high.
REQ-033 Write, adr=0x108, sel=4'hF, dat=0x5: tgt_we high one cycle with tgt_adr=0x108, tgt_data_o=0x5; ack; sel=4'h3: err, tgt_we stays low.
REQ-034 Target address 0xF000 returns err (no ack): wb_err_o one cycle; target rty held high: err after exactly 4 retries.
REQ-035 Silent target: wb_err_o asserts after 16 ACCESS cycles.
REQ-036 4-beat incrementing burst from 0x200 (cti 010,010,010,111): tgt_adr 0x200,0x204,0x208,0x20C, four acks; burst from 0xFFFC wraps to 0x0000.
REQ-037 cyc dropped mid-ACCESS and rst mid-RESP: no ack/err; FSM in IDLE next cycle; all outputs at reset values after rst.
